// File: rtl/prog_loader.sv
// Boot loader: receives a framed byte stream (length, payload, xor checksum), writes
// little-endian words to program memory and releases the core once the checksum matches.
module prog_loader #(
  parameter int ILen      = 32,
  parameter int AddrWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_data_i,
  output logic                 rx_ready_o,
  output logic                 pmem_we_o,
  output logic [AddrWidth-1:0] pmem_waddr_o,
  output logic [ILen-1:0]      pmem_wdata_o,
  output logic                 core_rst_no,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int WIdx = AddrWidth - 2;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [WIdx-1:0]       word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [ILen-1:0]       word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic                  pmem_we_q, pmem_we_d;
  logic [AddrWidth-1:0]  pmem_waddr_q, pmem_waddr_d;
  logic [ILen-1:0]       pmem_wdata_q, pmem_wdata_d;
  logic                  xfer;
  logic [15:0]           len_full;

  assign rx_ready_o   = (state_q == LEN0) || (state_q == LEN1) ||
                        (state_q == DATA) || (state_q == CSUM);
  assign busy_o       = rx_ready_o;
  assign done_o       = (state_q == DONE);
  assign core_rst_no  = (state_q == DONE);
  assign err_o        = (state_q == ERR);
  assign pmem_we_o    = pmem_we_q;
  assign pmem_waddr_o = pmem_waddr_q;
  assign pmem_wdata_o = pmem_wdata_q;

  assign xfer     = rx_valid_i && rx_ready_o;
  assign len_full = {rx_data_i, len_q[7:0]};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    csum_d       = csum_q;
    pmem_we_d    = 1'b0;
    pmem_waddr_d = pmem_waddr_q;
    pmem_wdata_d = pmem_wdata_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d    = LEN0;
          len_d      = '0;
          word_idx_d = '0;
          byte_idx_d = '0;
          word_d     = '0;
          csum_d     = '0;
        end
      end
      LEN0: begin
        if (xfer) begin
          len_d   = {8'h00, rx_data_i};
          state_d = LEN1;
        end
      end
      LEN1: begin
        if (xfer) begin
          len_d = len_full;
          if (32'(len_full) > (32'd1 << WIdx)) state_d = ERR;
          else if (len_full == 16'd0)          state_d = CSUM;
          else                                 state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          word_d[8*byte_idx_q +: 8] = rx_data_i;
          csum_d     = csum_q ^ rx_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Word complete: strobe lands in the next cycle (first CSUM cycle for the last word).
            pmem_we_d    = 1'b1;
            pmem_waddr_d = {word_idx_q, 2'b00};
            pmem_wdata_d = word_d;
            word_idx_d   = word_idx_q + 1'b1;
            if ((32'(word_idx_q) + 32'd1) == 32'(len_q)) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (xfer) state_d = (rx_data_i == csum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      pmem_we_q    <= 1'b0;
      pmem_waddr_q <= '0;
      pmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      pmem_we_q    <= pmem_we_d;
      pmem_waddr_q <= pmem_waddr_d;
      pmem_wdata_q <= pmem_wdata_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed streams with hand-computed writes and results.
module tb_prog_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_ready_o;
  logic        pmem_we_o;
  logic [15:0] pmem_waddr_o;
  logic [31:0] pmem_wdata_o;
  logic        core_rst_no;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;

  int          wr_cnt = 0;
  logic [15:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];

  prog_loader #(.ILen(32), .AddrWidth(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .pmem_we_o(pmem_we_o), .pmem_waddr_o(pmem_waddr_o), .pmem_wdata_o(pmem_wdata_o),
    .core_rst_no(core_rst_no), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (pmem_we_o) begin
      if (wr_cnt < 8) begin
        wr_addr[wr_cnt] = pmem_waddr_o;
        wr_data[wr_cnt] = pmem_wdata_o;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_load();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk_i);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    n = 0;
    while (!rx_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!rx_ready_o) check("byte_accept_timeout", 32'(rx_ready_o), 32'd1);
    @(negedge clk_i);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int max_gap);
    foreach (s[i]) send_byte(s[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    repeat (2) @(negedge clk_i);
  endtask

  task automatic check_nominal(input string tag);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd2);
    check({tag, "_addr0"}, 32'(wr_addr[0]), 32'h0000);
    check({tag, "_data0"}, wr_data[0], 32'h00A00513);
    check({tag, "_addr1"}, 32'(wr_addr[1]), 32'h0004);
    check({tag, "_data1"}, wr_data[1], 32'h00500593);
    check({tag, "_done"}, 32'(done_o), 32'd1);
    check({tag, "_core_rst_n"}, 32'(core_rst_no), 32'd1);
    check({tag, "_err"}, 32'(err_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(rx_ready_o), 32'd0);
    check({tag, "_we"}, 32'(pmem_we_o), 32'd0);
    check({tag, "_waddr"}, 32'(pmem_waddr_o), 32'd0);
    check({tag, "_wdata"}, pmem_wdata_o, 32'd0);
    check({tag, "_core_rst_n"}, 32'(core_rst_no), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
  endtask

  logic [7:0] nominal[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                             8'h93, 8'h05, 8'h50, 8'h00, 8'h70};
  logic [7:0] bad_csum[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
                              8'h93, 8'h05, 8'h50, 8'h00, 8'h71};
  logic [7:0] reload[$] = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
  logic [7:0] empty[$] = '{8'h00, 8'h00, 8'h00};
  logic [7:0] oversize[$] = '{8'h01, 8'h40};
  logic [7:0] max_len[$] = '{8'h00, 8'h40};
  logic [7:0] partial[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0};

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_reset_vals("reset");

    // Bytes offered in IDLE are not consumed.
    rx_valid_i = 1'b1; rx_data_i = 8'h55;
    repeat (3) @(negedge clk_i);
    check("idle_ready", 32'(rx_ready_o), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);
    rx_valid_i = 1'b0;

    // Nominal load.
    start_load();
    check("start_busy", 32'(busy_o), 32'd1);
    check("start_ready", 32'(rx_ready_o), 32'd1);
    wr_cnt = 0;
    send_stream(nominal, 0);
    check_nominal("nominal");

    // Bytes offered in DONE are not consumed.
    rx_valid_i = 1'b1; rx_data_i = 8'hAA;
    repeat (3) @(negedge clk_i);
    check("done_ready", 32'(rx_ready_o), 32'd0);
    check("done_hold", 32'(done_o), 32'd1);
    rx_valid_i = 1'b0;

    // Reload from DONE.
    start_load();
    check("reload_core_rst_n", 32'(core_rst_no), 32'd0);
    check("reload_done", 32'(done_o), 32'd0);
    check("reload_busy", 32'(busy_o), 32'd1);
    wr_cnt = 0;
    send_stream(reload, 0);
    check("reload_wr_cnt", 32'(wr_cnt), 32'd1);
    check("reload_addr0", 32'(wr_addr[0]), 32'h0000);
    check("reload_data0", wr_data[0], 32'h00000013);
    check("reload_done_end", 32'(done_o), 32'd1);

    // Bad checksum, then recover.
    start_load();
    wr_cnt = 0;
    send_stream(bad_csum, 0);
    check("badcs_wr_cnt", 32'(wr_cnt), 32'd2);
    check("badcs_err", 32'(err_o), 32'd1);
    check("badcs_core_rst_n", 32'(core_rst_no), 32'd0);
    check("badcs_done", 32'(done_o), 32'd0);
    start_load();
    check("err_clear", 32'(err_o), 32'd0);
    wr_cnt = 0;
    send_stream(nominal, 0);
    check_nominal("recover");

    // Empty program.
    start_load();
    wr_cnt = 0;
    send_stream(empty, 0);
    check("empty_wr_cnt", 32'(wr_cnt), 32'd0);
    check("empty_done", 32'(done_o), 32'd1);
    check("empty_core_rst_n", 32'(core_rst_no), 32'd1);

    // Oversize length: one past the maximum.
    start_load();
    wr_cnt = 0;
    send_stream(oversize, 0);
    check("oversize_err", 32'(err_o), 32'd1);
    check("oversize_busy", 32'(busy_o), 32'd0);
    rx_valid_i = 1'b1; rx_data_i = 8'h13;
    repeat (3) @(negedge clk_i);
    check("oversize_ready", 32'(rx_ready_o), 32'd0);
    rx_valid_i = 1'b0;
    check("oversize_wr_cnt", 32'(wr_cnt), 32'd0);

    // Exactly the maximum length is accepted and enters the payload phase.
    start_load();
    send_stream(max_len, 0);
    check("maxlen_err", 32'(err_o), 32'd0);
    check("maxlen_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;

    // Gapped rx_valid_i.
    start_load();
    wr_cnt = 0;
    send_stream(nominal, 4);
    check_nominal("gapped");

    // Reset mid-load after the 5th byte.
    start_load();
    wr_cnt = 0;
    foreach (partial[i]) send_byte(partial[i], 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_reset_vals("midrst");
    repeat (6) @(negedge clk_i);
    check("midrst_wr_cnt", 32'(wr_cnt), 32'd0);
    check("midrst_idle_busy", 32'(busy_o), 32'd0);
    start_load();
    send_stream(nominal, 0);
    check_nominal("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot sequencer for the single-cycle RISC-V core.
- Holds the core in reset and receives a framed byte stream (length, payload, checksum) over a valid/ready byte interface.
- Assembles little-endian 32-bit words and writes them to program memory starting at byte address 0.
- Releases the core only after the checksum matches.
- Sits between a serial receiver (UART RX or similar) and the pmem write port / core reset.

Parameters:
- ILen, 32, instruction word width; must be 32.
- AddrWidth, 16, program memory byte-address width, matching the core's pmem_addr_o width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  begin a load; sampled in IDLE, DONE, ERR.
- rx_valid_i  input  1  byte available.
- rx_data_i  input  8  byte value.
- rx_ready_o  output  1  loader accepts byte; transfer occurs when rx_valid_i & rx_ready_o.
- pmem_we_o  output  1  program memory write strobe, one cycle per word.
- pmem_waddr_o  output  AddrWidth  byte address of write, word-aligned (bits [1:0] = 0).
- pmem_wdata_o  output  ILen  write data.
- core_rst_no  output  1  active-low core reset; 0 holds core.
- busy_o  output  1  load in progress.
- done_o  output  1  program loaded and verified.
- err_o  output  1  load failed (length or checksum).

Behaviour:
- Interface (decided): one clock, clk_i. Reset rst_i is synchronous and active-high: the design samples it on the rising edge of clk_i, and it overrides all other inputs.
- Reset values: state = IDLE; rx_ready_o = 0, pmem_we_o = 0, pmem_waddr_o = 0, pmem_wdata_o = 0, core_rst_no = 0, busy_o = 0, done_o = 0, err_o = 0; word counter, byte index and checksum cleared.
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR. All outputs are registered or decoded from the state register only.
- rx_ready_o = 1 in LEN0, LEN1, DATA, CSUM; 0 otherwise. Bytes presented in other states are ignored and not consumed.
- busy_o = 1 in LEN0 through CSUM.
- core_rst_no = 1 only in DONE.
- IDLE: start_i -> LEN0.
- LEN0: on transfer, N[7:0] = byte -> LEN1.
- LEN1: on transfer, N[15:8] = byte. Next state:
  - N > 2^(AddrWidth-2) -> ERR;
  - N == 0 -> CSUM;
  - else -> DATA.
  - Length bytes are not included in the checksum.
- DATA: each transferred byte shifts into the word register little-endian (byte k -> bits [8k+7:8k], k = 0..3) and is XORed into an 8-bit checksum.
  - On the 4th byte of a word, the next cycle drives pmem_we_o = 1 for exactly one cycle, with pmem_waddr_o = word_index*4 and pmem_wdata_o = the assembled word; word_index then increments.
  - A byte may be accepted in the same cycle as the write pulse (no bubble required).
  - After the 4th byte of word N-1 -> CSUM.
- CSUM: on transfer, compare the byte with the checksum; equal -> DONE, else -> ERR.
  - The final word's write pulse completes no later than the first CSUM cycle, so it always precedes release.
- DONE: done_o = 1, core_rst_no = 1. start_i -> LEN0 (reload): core_rst_no drops to 0 the next cycle, done_o clears, counters and checksum clear.
- ERR: err_o = 1, core stays held. start_i -> LEN0 with err_o cleared and counters/checksum cleared. Words already written are not rolled back.
- Address wrap is impossible: N is bounded in LEN1, so the word index never exceeds 2^(AddrWidth-2) - 1.
- rst_i mid-operation: the next cycle is IDLE with all reset values. No further pmem_we_o is issued, including a write pending from a just-completed word.
- start_i while busy: ignored.
- rx_valid_i low for any number of cycles stalls the FSM with no state change.

Test Plan:
- Nominal load: start_i, then bytes 02 00 13 05 A0 00 93 05 50 00 70 -> writes (addr 0x0000, 0x00A00513), then (0x0004, 0x00500593); then done_o = 1 and core_rst_no = 1; exactly 2 write pulses.
- Bad checksum: same stream with final byte 71 -> both writes occur; err_o = 1, core_rst_no = 0, done_o = 0. Then start_i plus the correct stream -> done_o = 1.
- Empty and oversize: stream 00 00 00 -> done_o = 1 with no writes. With AddrWidth = 16, stream 01 40 (N = 0x4001) -> ERR right after LEN1, no writes, following bytes not consumed (rx_ready_o = 0).
- Backpressure and gaps: nominal stream with randomly gapped rx_valid_i -> identical write sequence and result. Bytes offered in IDLE or DONE -> rx_ready_o = 0, not consumed.
- Reset mid-load: assert rst_i for 1 cycle after the 5th byte of the nominal stream -> IDLE, no write at 0x0004, all outputs at reset values. A fresh start_i plus the nominal stream -> correct result.
- Reload from DONE: after the nominal load, start_i -> core_rst_no = 0 the next cycle. Stream 01 00 13 00 00 00 13 -> write (0x0000, 0x00000013), then DONE.
